// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store front end: size codes,
// FSM state encoding and the byte/halfword lane masks.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    // Right-aligned lane masks, shifted into position by the lane offset.
    localparam logic [31:0] LANE_MASK_B = 32'h0000_00ff;
    localparam logic [31:0] LANE_MASK_H = 32'h0000_ffff;
    localparam logic [31:0] LANE_MASK_W = 32'hffff_ffff;

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and word-memory port bundle.
//   req_*     : MEM-stage request (valid, read, write, size, unsigned, addr, wdata)
//   rdata/stall/err : response to the pipeline
//   mem_*     : word-only data memory port (mem_rdata is combinational from mem_addr)
// slave = the access unit, master = pipeline + memory side.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_read;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       rdata;
    logic              stall;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_read, req_write, req_size, req_unsigned,
               req_addr, req_wdata, mem_rdata,
        output rdata, stall, err, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_read, req_write, req_size, req_unsigned,
               req_addr, req_wdata, mem_rdata,
        input  rdata, stall, err, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts/extends the addressed load lane of a
// memory word and builds the merged word for a sub-word store.
//   word_i     : word read from memory
//   off_i      : byte offset addr[1:0]
//   size_i     : access size code
//   unsigned_i : zero-extend instead of sign-extend
//   wdata_i    : right-aligned store data
//   load_o     : extended load data
//   merge_o    : word_i with the addressed lane(s) replaced by wdata_i
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] shifted;

    // Bit position of the addressed lane; big-endian mirrors the offset.
    always_comb begin
        sh        = 5'd0;
        lane_mask = LANE_MASK_W;
        case (size_i)
            SZ_BYTE: begin
                sh        = BIG_ENDIAN ? {~off_i, 3'b000} : {off_i, 3'b000};
                lane_mask = LANE_MASK_B;
            end
            SZ_HALF: begin
                sh        = BIG_ENDIAN ? {~off_i[1], 4'b0000} : {off_i[1], 4'b0000};
                lane_mask = LANE_MASK_H;
            end
            default: ;
        endcase
    end

    assign shifted = word_i >> sh;

    always_comb begin
        load_o = word_i;
        case (size_i)
            SZ_BYTE: load_o = unsigned_i ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_o = unsigned_i ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    assign merge_o = (word_i & ~(lane_mask << sh)) | ((wdata_i & lane_mask) << sh);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a word-only data memory.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request/response and memory port bundle (slave side)
// Loads complete in the request cycle; word stores write directly; sub-word
// stores read the word, merge, and write it back one cycle later (one stall).
// Outputs are combinational and forced to zero while reset is asserted.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_unit_if.slave    bus
);

    state_e            state_q, state_d;
    logic [31:0]       merge_q, merge_d;

    logic [ADDR_W-1:0] word_addr;
    logic              illegal;
    logic              misaligned;
    logic [31:0]       load_data;
    logic [31:0]       merge_word;

    logic [31:0]       rdata_c;
    logic              stall_c;
    logic              err_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [31:0]       mem_wdata_c;
    logic              mem_read_c;
    logic              mem_write_c;

    assign word_addr  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    assign illegal    = (bus.req_size == SZ_ILLEGAL) || (bus.req_read && bus.req_write);
    assign misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                        ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .word_i     (bus.mem_rdata),
        .off_i      (bus.req_addr[1:0]),
        .size_i     (bus.req_size),
        .unsigned_i (bus.req_unsigned),
        .wdata_i    (bus.req_wdata),
        .load_o     (load_data),
        .merge_o    (merge_word)
    );

    // State and merge register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

    // Next state and outputs.
    always_comb begin
        state_d     = state_q;
        merge_d     = merge_q;
        rdata_c     = 32'h0;
        stall_c     = 1'b0;
        err_c       = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = 32'h0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (illegal || misaligned) begin
                        err_c = 1'b1;
                    end else if (bus.req_read) begin
                        mem_read_c = 1'b1;
                        mem_addr_c = word_addr;
                        rdata_c    = load_data;
                    end else if (bus.req_write) begin
                        mem_addr_c = word_addr;
                        if (bus.req_size == SZ_WORD) begin
                            mem_write_c = 1'b1;
                            mem_wdata_c = bus.req_wdata;
                        end else begin
                            // Read phase of read-modify-write.
                            mem_read_c = 1'b1;
                            stall_c    = 1'b1;
                            merge_d    = merge_word;
                            state_d    = ST_RMW_WR;
                        end
                    end
                end
            end
            ST_RMW_WR: begin
                // Write phase; the held request is not re-decoded here.
                mem_write_c = 1'b1;
                mem_addr_c  = word_addr;
                mem_wdata_c = merge_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset drops any pending store and silences the port.
        if (reset) begin
            state_d     = ST_IDLE;
            merge_d     = 32'h0;
            rdata_c     = 32'h0;
            stall_c     = 1'b0;
            err_c       = 1'b0;
            mem_addr_c  = '0;
            mem_wdata_c = 32'h0;
            mem_read_c  = 1'b0;
            mem_write_c = 1'b0;
        end
    end

    assign bus.rdata     = rdata_c;
    assign bus.stall     = stall_c;
    assign bus.err       = err_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory, reference model with its own
// shadow memory checked every cycle, and directed literal checks.
module tb_mem_access_unit;

    localparam logic [31:0] PRE0 = 32'hf92aafe5;
    localparam logic [31:0] PRE1 = 32'h13572468;

    logic clk = 1'b0;
    logic reset;
    logic reload;

    int total = 0;
    int bad   = 0;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .BIG_ENDIAN (1'b0),
        .ADDR_W     (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word memory, 16 words, combinational read.
    logic [31:0] mem [16];
    assign bus.mem_rdata = (bus.mem_addr[31:6] == 26'h0) ? mem[bus.mem_addr[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (reload) begin
            mem[0] <= PRE0;
            mem[1] <= PRE1;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16];
    logic        pend      = 1'b0;
    logic [31:0] pend_word = 32'h0;
    logic        n_pend    = 1'b0;
    logic [31:0] n_pw      = 32'h0;
    logic        n_we      = 1'b0;
    logic [3:0]  n_wi      = 4'h0;
    logic [31:0] n_wv      = 32'h0;

    function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] off,
                                               logic [1:0] sz, logic u);
        logic [31:0] s;
        s = w >> (int'(off) * 8);
        case (sz)
            2'd0:    return u ? (s & 32'hff)   : {{24{s[7]}}, s[7:0]};
            2'd1:    return u ? (s & 32'hffff) : {{16{s[15]}}, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(logic [31:0] w, logic [1:0] off,
                                                logic [1:0] sz, logic [31:0] d);
        logic [31:0] m;
        m = (sz == 2'd0) ? 32'hff : 32'hffff;
        return (w & ~(m << (int'(off) * 8))) | ((d & m) << (int'(off) * 8));
    endfunction

    always @(negedge clk) begin
        logic [31:0] e_rd, e_addr, e_wd, wa, cur;
        logic        e_st, e_err, e_re, e_we, bad_req;
        logic [3:0]  idx;
        e_rd = 0; e_addr = 0; e_wd = 0; e_st = 0; e_err = 0; e_re = 0; e_we = 0;
        n_pend = 1'b0; n_pw = pend_word; n_we = 1'b0; n_wi = 4'h0; n_wv = 32'h0;
        wa  = {bus.req_addr[31:2], 2'b00};
        idx = bus.req_addr[5:2];
        cur = ref_mem[idx];
        bad_req = (bus.req_size == 2'd3) || (bus.req_read && bus.req_write) ||
                  (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                  (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
        if (reset) begin
            n_pw = 32'h0;
        end else if (pend) begin
            e_we = 1; e_addr = wa; e_wd = pend_word;
            n_we = 1; n_wi = idx; n_wv = pend_word;
        end else if (bus.req_valid) begin
            if (bad_req) begin
                e_err = 1;
            end else if (bus.req_read) begin
                e_re = 1; e_addr = wa;
                e_rd = model_load(cur, bus.req_addr[1:0], bus.req_size, bus.req_unsigned);
            end else if (bus.req_write && bus.req_size == 2'd2) begin
                e_we = 1; e_addr = wa; e_wd = bus.req_wdata;
                n_we = 1; n_wi = idx; n_wv = bus.req_wdata;
            end else if (bus.req_write) begin
                e_re = 1; e_st = 1; e_addr = wa;
                n_pend = 1'b1;
                n_pw = model_merge(cur, bus.req_addr[1:0], bus.req_size, bus.req_wdata);
            end
        end
        check("m_stall", {31'h0, bus.stall}, {31'h0, e_st});
        check("m_err", {31'h0, bus.err}, {31'h0, e_err});
        check("m_mem_read", {31'h0, bus.mem_read}, {31'h0, e_re});
        check("m_mem_write", {31'h0, bus.mem_write}, {31'h0, e_we});
        check("m_rdata", bus.rdata, e_rd);
        if (reset || e_re || e_we) check("m_mem_addr", bus.mem_addr, e_addr);
        if (reset || e_we) check("m_mem_wdata", bus.mem_wdata, e_wd);
    end

    always @(posedge clk) begin
        if (reload) begin
            ref_mem[0] <= PRE0;
            ref_mem[1] <= PRE1;
        end else if (n_we) begin
            ref_mem[n_wi] <= n_wv;
        end
        pend      <= n_pend;
        pend_word <= n_pw;
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input logic rst);
        @(posedge clk);
        #1;
        bus.req_valid    = v;
        bus.req_read     = rd;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        reset            = rst;
        reload           = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reload();
        idle();
        reload = 1'b1;
    endtask

    initial begin
        reset = 1'b1; reload = 1'b1;
        bus.req_valid = 0; bus.req_read = 0; bus.req_write = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
        @(negedge clk);
        check("rst_stall", {31'h0, bus.stall}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
        idle();

        // 1-2: loads
        step(1, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0);
        check("lb0", bus.rdata, 32'hffffffe5);
        check("lb0_stall", {31'h0, bus.stall}, 32'h0);
        step(1, 1, 0, 2'd0, 1, 32'h0, 32'h0, 0);
        check("lbu0", bus.rdata, 32'h000000e5);
        step(1, 1, 0, 2'd1, 0, 32'h2, 32'h0, 0);
        check("lh2", bus.rdata, 32'hfffff92a);
        step(1, 1, 0, 2'd1, 1, 32'h2, 32'h0, 0);
        check("lhu2", bus.rdata, 32'h0000f92a);
        step(1, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0);
        check("lw0", bus.rdata, 32'hf92aafe5);

        // 3: byte store RMW
        step(1, 0, 1, 2'd0, 0, 32'h1, 32'h12345677, 0);
        check("sb1_stall", {31'h0, bus.stall}, 32'h1);
        check("sb1_read", {31'h0, bus.mem_read}, 32'h1);
        step(1, 0, 1, 2'd0, 0, 32'h1, 32'h12345677, 0);
        check("sb1_write", {31'h0, bus.mem_write}, 32'h1);
        check("sb1_wdata", bus.mem_wdata, 32'hf92a77e5);
        step(1, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0);
        check("lw0_after_sb", bus.rdata, 32'hf92a77e5);

        // 4: misaligned / illegal
        step(1, 1, 0, 2'd1, 0, 32'h1, 32'h0, 0);
        check("lh1_err", {31'h0, bus.err}, 32'h1);
        check("lh1_read", {31'h0, bus.mem_read}, 32'h0);
        check("lh1_rdata", bus.rdata, 32'h0);
        idle();
        check("err_pulse", {31'h0, bus.err}, 32'h0);
        step(1, 0, 1, 2'd2, 0, 32'h6, 32'hdeadbeef, 0);
        check("sw6_err", {31'h0, bus.err}, 32'h1);
        check("sw6_write", {31'h0, bus.mem_write}, 32'h0);
        step(1, 1, 0, 2'd2, 0, 32'h4, 32'h0, 0);
        check("lw4_unchanged", bus.rdata, PRE1);
        step(1, 1, 0, 2'd3, 0, 32'h0, 32'h0, 0);
        check("size3_err", {31'h0, bus.err}, 32'h1);
        step(1, 1, 1, 2'd2, 0, 32'h0, 32'h0, 0);
        check("rdwr_err", {31'h0, bus.err}, 32'h1);

        // 5: reset during write phase
        do_reload();
        step(1, 0, 1, 2'd1, 0, 32'h0, 32'h0000beef, 0);
        check("sh0_stall", {31'h0, bus.stall}, 32'h1);
        step(1, 0, 1, 2'd1, 0, 32'h0, 32'h0000beef, 1);
        check("sh0_rst_write", {31'h0, bus.mem_write}, 32'h0);
        idle();
        check("sh0_idle_stall", {31'h0, bus.stall}, 32'h0);
        check("sh0_idle_write", {31'h0, bus.mem_write}, 32'h0);
        step(1, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0);
        check("lw0_after_rst", bus.rdata, 32'hf92aafe5);

        // 6: back-to-back byte stores
        step(1, 0, 1, 2'd0, 0, 32'h0, 32'h11, 0);
        check("sb0_stall", {31'h0, bus.stall}, 32'h1);
        step(1, 0, 1, 2'd0, 0, 32'h0, 32'h11, 0);
        check("sb0_wdata", bus.mem_wdata, 32'hf92aaf11);
        check("sb0_nostall", {31'h0, bus.stall}, 32'h0);
        step(1, 0, 1, 2'd0, 0, 32'h3, 32'h22, 0);
        check("sb3_stall", {31'h0, bus.stall}, 32'h1);
        step(1, 0, 1, 2'd0, 0, 32'h3, 32'h22, 0);
        check("sb3_wdata", bus.mem_wdata, 32'h222aaf11);
        step(1, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0);
        check("lw0_final", bus.rdata, 32'h222aaf11);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
